// File: rtl/pcs_8b10b_pkg.sv
// pcs_8b10b_pkg: 1000BASE-X 8B/10B character constants, TX ordered-set states, idle counter width
package pcs_8b10b_pkg;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K30_7 = 8'hFE;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam int IDLE_CNT_W = 4;
  typedef enum logic [2:0] {
    IDLE_K = 3'd0,
    IDLE_D = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    END_T  = 3'd4,
    END_R1 = 3'd5,
    END_R2 = 3'd6,
    EXTEND = 3'd7
  } tx_state_t;
endpackage

// File: rtl/pcs_tx_ordered_set.sv
// pcs_tx_ordered_set: GMII TX to 8B/10B encoder sequencer (idles, /S/ /T/ /R/ /V/, even alignment); CARRIER_EXT_EN adds carrier extension.
// Ports: GTX_CLK clock, RESET sync active-high; TXD/TX_EN/TX_ER GMII in; RD encoder disparity;
// ENC_DATA/ENC_K/ENC_VALID to encoder; TX_EVEN code-group parity; TX_DROP discarded-octet pulse.
module pcs_tx_ordered_set
  import pcs_8b10b_pkg::*;
#(
  parameter int MIN_IDLE_SETS = 1
) (
  input  logic       GTX_CLK,
  input  logic       RESET,
  input  logic [7:0] TXD,
  input  logic       TX_EN,
  input  logic       TX_ER,
  input  logic       RD,
  output logic [7:0] ENC_DATA,
  output logic       ENC_K,
  output logic       ENC_VALID,
  output logic       TX_EVEN,
  output logic       TX_DROP
);
  localparam logic [IDLE_CNT_W-1:0] MIN = IDLE_CNT_W'(MIN_IDLE_SETS);
  tx_state_t state, nxt;
  logic [IDLE_CNT_W-1:0] cnt, cnt_inc;
  logic [7:0] data;
  logic k, drop, clr, start;
`ifdef CARRIER_EXT_EN
  logic ext;
`endif
  // TX_EVEN holds the parity of the group just sent, so END_R1 sees the /T/ parity directly
  always_comb begin
    cnt_inc = (cnt == MIN) ? cnt : cnt + 1'b1;
    start = TX_EN && cnt_inc == MIN;
    nxt = IDLE_K;
    data = K28_5;
    k = 1'b1;
    drop = 1'b0;
    clr = 1'b0;
`ifdef CARRIER_EXT_EN
    ext = !TX_EN && TX_ER;
`endif
    case (state)
      IDLE_K: begin
        nxt = IDLE_D;
        drop = TX_EN;
      end
      IDLE_D: begin
        data = RD ? D5_6 : D16_2;
        k = 1'b0;
        nxt = start ? START : IDLE_K;
        drop = TX_EN && !start;
      end
      START: nxt = DATA;
      DATA: begin
        data = !TX_EN ? K29_7 : TX_ER ? K30_7 : TXD;
        k = !TX_EN || TX_ER;
`ifdef CARRIER_EXT_EN
        nxt = TX_EN ? DATA : ext ? EXTEND : END_R1;
`else
        nxt = TX_EN ? DATA : END_R1;
`endif
      end
      END_R1: begin
        data = K23_7;
        nxt = TX_EVEN ? IDLE_K : END_R2;
        clr = TX_EVEN;
      end
      END_R2: begin
        data = K23_7;
        clr = 1'b1;
      end
`ifdef CARRIER_EXT_EN
      EXTEND: begin
        data = ext && TXD != 8'h0F ? K30_7 : K23_7;
        nxt = ext ? EXTEND : TX_EVEN ? IDLE_K : END_R2;
        clr = !ext && TX_EVEN;
      end
`endif
      default: ;
    endcase
    if (state == START) data = K27_7;
  end
  always_ff @(posedge GTX_CLK) begin
    if (RESET) begin
      ENC_DATA <= 8'h00;
      ENC_K <= 1'b0;
      ENC_VALID <= 1'b0;
      TX_DROP <= 1'b0;
      TX_EVEN <= 1'b0;
      state <= IDLE_K;
      cnt <= MIN;
    end else begin
      ENC_DATA <= data;
      ENC_K <= k;
      ENC_VALID <= 1'b1;
      TX_DROP <= drop;
      TX_EVEN <= !TX_EVEN;
      state <= nxt;
      cnt <= clr ? '0 : state == IDLE_D ? cnt_inc : cnt;
    end
  end
endmodule
